dds_cmd_tx: RTL and testbench
=============================

# dds_cmd_tx

Host-side command frame transmitter for the DDS generator: the sending end of the UART command protocol that `communication` decodes. It takes a frequency tuning word or an enable/disable request, serializes it into a checksummed byte frame over the `uart` transmit handshake, then waits for the ACK/NACK reply byte or a timeout. It is used on the controller board and as the stimulus driver in generator system benches.

## Interface
- `TIMEOUT_CYCLES`, 120000: cycles to wait for a reply after the last frame byte; 10 ms at 12 MHz.
- `clk`  in  1  system clock, 12 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `send`  in  1  one-cycle request; accepted only when `busy`=0.
- `cmd`  in  2  0=set frequency, 1=enable, 2=disable, 3=reserved.
- `m_in`  in  40  tuning word; used only for `cmd`=0.
- `busy`  out  1  high from the accepted `send` until `done`.
- `done`  out  1  one-cycle pulse at the end of a transaction.
- `ack_ok`, `nack`, `timeout`  out  1 each  result flags; at most one is set; held until the next accepted `send`.
- `transmit`  out  1  one-cycle byte strobe to `uart`.
- `tx_byte`  out  8  byte for `uart`; valid while `transmit`=1.
- `is_transmitting`  in  1  `uart` busy flag.
- `received`  in  1  `uart` rx strobe.
- `rx_byte`  in  8  received byte; valid with `received`.

## Operation
- Frames:
  - set frequency: 0x46, then `m_in[39:32]` through `m_in[7:0]` (big-endian), then checksum; 7 bytes.
  - enable: 0x45, checksum; 2 bytes.
  - disable: 0x44, checksum; 2 bytes.
  - Checksum is the XOR of all preceding frame bytes.
- Reply bytes: 0x06 sets `ack_ok`, 0x15 sets `nack`. Any other byte is ignored and the wait continues.
- `cmd` and `m_in` are latched on the accepted `send`. Later changes to them have no effect on the frame in progress.
- `send` while `busy`=1 is ignored.
- `cmd`=3: no bytes are sent. `busy` is high for one cycle, then `done` pulses with `nack`=1.
- States and transitions:
  - IDLE → LOAD when `send` is accepted.
  - LOAD latches inputs and clears the flags → SEND.
  - SEND drives `transmit`=1 and `tx_byte` for one cycle → HOLD.
  - HOLD waits one cycle so `uart` can raise `is_transmitting` → WAIT_TX.
  - WAIT_TX exits when `is_transmitting`=0: to SEND if bytes remain, else to WAIT_ACK.
  - WAIT_ACK → FINISH on a valid reply byte or on timer expiry.
  - FINISH pulses `done`, drops `busy` → IDLE.
- `received` is ignored in every state except WAIT_ACK.
- Timer:
  - Loaded with `TIMEOUT_CYCLES`-1 on entry to WAIT_ACK and decrements each cycle.
  - Expiry at 0 sets `timeout`.
  - If a valid reply byte arrives in the same cycle as expiry, the reply byte takes precedence.
- Byte index counter: 3 bits, counts 0..frame_len-1, no wrap beyond the frame length.

## Timing
- Reset values: `busy`=0, `done`=0, `ack_ok`=0, `nack`=0, `timeout`=0, `transmit`=0, `tx_byte`=0x00; state IDLE.
- `send` sampled high at edge N → `busy`=1 after N, `transmit` pulse in the cycle after N+1 (LOAD then SEND).
- Byte spacing is set by `uart`: the next `transmit` comes 1 cycle after `is_transmitting` falls.
- Reply sampled at edge R → `done` and result flag visible after R+1.
- Timeout: `done` follows WAIT_ACK entry by `TIMEOUT_CYCLES`+1 cycles.
- Reset mid-frame: state returns to IDLE and all outputs go to reset values asynchronously. A byte already handed to `uart` completes on the wire. No partial-frame recovery is attempted; the receiver's checksum rejects the fragment.

## Structure
- Shared package `dds_cmd_pkg` holds the values used by both this block and `communication`:
  - opcode constants 0x46, 0x45, 0x44
  - ACK 0x06 and NACK 0x15
  - the `cmd` encoding enum
  - frame lengths 7 and 2
  - state typedef
- One natural sub-module, `dds_cmd_frame`: combinational byte selector that maps (latched cmd, latched m, index, running checksum) to `tx_byte`. The FSM, running XOR register and timer stay in the top.

## Test plan
- `cmd`=0, `m_in`=0x0123456789, bench `uart` model replies 0x06 → bytes 46 01 23 45 67 89 CF in order; `ack_ok`=1; one `done` pulse.
- `cmd`=1 with reply 0x15 → bytes 45 45; `nack`=1. Then `cmd`=2 with reply 0x06 → bytes 44 44; `ack_ok`=1 and `nack` cleared.
- `TIMEOUT_CYCLES`=50, no reply → `timeout`=1 exactly 51 cycles after WAIT_ACK entry. Reply 0x06 injected on the expiry cycle → `ack_ok`=1, `timeout`=0.
- Extra stimulus on a frequency frame:
  - `send` pulsed and `m_in` changed mid-frame → frame unchanged, one `done`.
  - `received`=0x06 during WAIT_TX → ignored.
  - junk byte 0x41 during WAIT_ACK → still waiting.
- `rst_n` low after byte 3 of a frequency frame → outputs at reset values immediately. A new `send` after release → full 7-byte frame starting at 0x46.
- `cmd`=3 → no `transmit` pulses; `nack`=1 and `done` two cycles after `send`.

Source files
------------

// File: rtl/dds_cmd_pkg.sv
// dds_cmd_pkg: values shared by the DDS command transmitter and receiver.
// Opcodes, reply bytes, cmd encoding, frame lengths, tx FSM states.
package dds_cmd_pkg;

  localparam logic [7:0] OP_SET_FREQ = 8'h46;
  localparam logic [7:0] OP_ENABLE   = 8'h45;
  localparam logic [7:0] OP_DISABLE  = 8'h44;

  localparam logic [7:0] BYTE_ACK  = 8'h06;
  localparam logic [7:0] BYTE_NACK = 8'h15;

  localparam logic [2:0] LEN_FREQ = 3'd7;
  localparam logic [2:0] LEN_CTRL = 3'd2;

  typedef enum logic [1:0] {
    CMD_SET_FREQ = 2'd0,
    CMD_ENABLE   = 2'd1,
    CMD_DISABLE  = 2'd2,
    CMD_RSVD     = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_HOLD,
    S_WAIT_TX,
    S_WAIT_ACK,
    S_FINISH
  } tx_state_e;

  typedef enum logic [1:0] {
    RES_ACK,
    RES_NACK,
    RES_TIMEOUT
  } res_e;

  function automatic logic [2:0] frame_len(
    input logic [1:0] c
  );
    return (c == CMD_SET_FREQ) ? LEN_FREQ
                               : LEN_CTRL;
  endfunction

endpackage

// File: rtl/dds_cmd_frame.sv
// dds_cmd_frame: picks the frame byte at idx for a latched command.
// In: cmd, m, idx, csum (running XOR). Out: byte_out.
module dds_cmd_frame
  import dds_cmd_pkg::*;
(
  input  logic [1:0]  cmd,
  input  logic [39:0] m,
  input  logic [2:0]  idx,
  input  logic [7:0]  csum,
  output logic [7:0]  byte_out
);

  logic       is_freq;
  logic [7:0] opcode;
  logic [7:0] m_byte;

  assign is_freq = (cmd == CMD_SET_FREQ);

  always_comb begin
    opcode = 8'h00;
    unique case (cmd_e'(cmd))
      CMD_SET_FREQ: opcode = OP_SET_FREQ;
      CMD_ENABLE:   opcode = OP_ENABLE;
      CMD_DISABLE:  opcode = OP_DISABLE;
      default:      opcode = 8'h00;
    endcase
  end

  // tuning word goes out MSB first at idx 1..5
  always_comb begin
    m_byte = m[7:0];
    case (idx)
      3'd1:    m_byte = m[39:32];
      3'd2:    m_byte = m[31:24];
      3'd3:    m_byte = m[23:16];
      3'd4:    m_byte = m[15:8];
      default: m_byte = m[7:0];
    endcase
  end

  // whatever follows the payload is the checksum
  always_comb begin
    byte_out = csum;
    unique case (1'b1)
      (idx == 3'd0):
        byte_out = opcode;
      (is_freq && idx >= 3'd1 && idx <= 3'd5):
        byte_out = m_byte;
      default:
        byte_out = csum;
    endcase
  end

endmodule

// File: rtl/dds_cmd_tx.sv
// dds_cmd_tx: sends a checksummed DDS command frame, awaits ACK/NACK.
// send/cmd/m_in in; busy/done/flags out; transmit/tx_byte to uart.
module dds_cmd_tx
  import dds_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send,
  input  logic [1:0]  cmd,
  input  logic [39:0] m_in,
  output logic        busy,
  output logic        done,
  output logic        ack_ok,
  output logic        nack,
  output logic        timeout,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  input  logic        is_transmitting,
  input  logic        received,
  input  logic [7:0]  rx_byte
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LOAD =
    TW'(TIMEOUT_CYCLES - 1);

  tx_state_e   state;
  res_e        res;
  logic [1:0]  cmd_q;
  logic [39:0] m_q;
  logic [2:0]  idx;
  logic [7:0]  csum;
  logic [TW-1:0] timer;
  logic [7:0]  frame_byte;
  logic        reply_ack;
  logic        reply_nack;

  assign reply_ack  = received &&
                      (rx_byte == BYTE_ACK);
  assign reply_nack = received &&
                      (rx_byte == BYTE_NACK);

  dds_cmd_frame u_frame (
    .cmd      (cmd_q),
    .m        (m_q),
    .idx      (idx),
    .csum     (csum),
    .byte_out (frame_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      res      <= RES_ACK;
      cmd_q    <= '0;
      m_q      <= '0;
      idx      <= '0;
      csum     <= '0;
      timer    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_ok   <= 1'b0;
      nack     <= 1'b0;
      timeout  <= 1'b0;
      transmit <= 1'b0;
      tx_byte  <= '0;
    end else begin
      done     <= 1'b0;
      transmit <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (send) begin
            cmd_q <= cmd;
            m_q   <= m_in;
            idx   <= '0;
            csum  <= '0;
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          ack_ok  <= 1'b0;
          nack    <= 1'b0;
          timeout <= 1'b0;
          if (cmd_q == CMD_RSVD) begin
            nack  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            transmit <= 1'b1;
            tx_byte  <= frame_byte;
            csum     <= csum ^ frame_byte;
            idx      <= idx + 3'd1;
            state    <= S_SEND;
          end
        end
        S_SEND: state <= S_HOLD;
        S_HOLD: state <= S_WAIT_TX;
        S_WAIT_TX: begin
          if (!is_transmitting) begin
            if (idx < frame_len(cmd_q)) begin
              transmit <= 1'b1;
              tx_byte  <= frame_byte;
              csum     <= csum ^ frame_byte;
              idx      <= idx + 3'd1;
              state    <= S_SEND;
            end else begin
              timer <= TIMER_LOAD;
              state <= S_WAIT_ACK;
            end
          end
        end
        S_WAIT_ACK: begin
          // a reply on the expiry cycle wins
          if (reply_ack) begin
            res   <= RES_ACK;
            state <= S_FINISH;
          end else if (reply_nack) begin
            res   <= RES_NACK;
            state <= S_FINISH;
          end else if (timer == '0) begin
            res   <= RES_TIMEOUT;
            state <= S_FINISH;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          ack_ok  <= (res == RES_ACK);
          nack    <= (res == RES_NACK);
          timeout <= (res == RES_TIMEOUT);
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_cmd_tx.sv
// tb_dds_cmd_tx: random command frames against a frame/reply model.
// Includes a uart stand-in that stretches is_transmitting per byte.
module tb_dds_cmd_tx;

  localparam int T   = 50;
  localparam int BIG = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        send = 1'b0;
  logic [1:0]  cmd = '0;
  logic [39:0] m_in = '0;
  logic        busy, done, ack_ok, nack, timeout;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        is_transmitting = 1'b0;
  logic        received = 1'b0;
  logic [7:0]  rx_byte = '0;

  initial forever #5 clk = ~clk;

  dds_cmd_tx #(.TIMEOUT_CYCLES(T)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .send            (send),
    .cmd             (cmd),
    .m_in            (m_in),
    .busy            (busy),
    .done            (done),
    .ack_ok          (ack_ok),
    .nack            (nack),
    .timeout         (timeout),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .is_transmitting (is_transmitting),
    .received        (received),
    .rx_byte         (rx_byte)
  );

  int errors = 0;
  int checks = 0;

  function automatic void chk(
    input bit ok, input string name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endfunction

  typedef enum {P_IDLE, P_TX, P_ACK} phase_e;
  phase_e phase = P_IDLE;

  int cyc = 0, acc = 0, wa = BIG, last_tx = 0;
  int exp_done = BIG, bytes_sent = 0, done_at = 0;
  int rst_cnt = 3, ucnt = 0;
  logic [2:0] exp_flags = '0, exp_res = '0;
  logic [7:0] exp_q[$];
  logic [7:0] rec_q[$];

  logic [1:0]  p_cmd;
  logic [39:0] p_m;
  logic [7:0]  p_rb;
  int p_rw, p_jw, p_rst;
  bit p_early, p_mid;
  bit go = 0, complete = 0;
  bit first_tx = 0, early_done = 0;

  function automatic void build(
    input logic [1:0] c, input logic [39:0] m
  );
    logic [7:0] x;
    exp_q.delete();
    if (c == 2'd3) return;
    case (c)
      2'd0: begin
        exp_q.push_back(8'h46);
        for (int i = 4; i >= 0; i--)
          exp_q.push_back(m[8*i +: 8]);
      end
      2'd1: exp_q.push_back(8'h45);
      default: exp_q.push_back(8'h44);
    endcase
    x = '0;
    foreach (exp_q[i]) x ^= exp_q[i];
    exp_q.push_back(x);
  endfunction

  task automatic chk_reset_vals(input string nm);
    chk({busy, done, ack_ok, nack, timeout,
         transmit, tx_byte} == '0, nm,
        {busy, done, ack_ok, nack, timeout,
         transmit, tx_byte}, 0);
  endtask

  // model + uart stand-in + compare, all on the falling edge
  initial begin
    logic [63:0] tmp;
    logic [7:0]  b;
    logic [2:0]  flags;
    bit          valid;
    int          w;
    forever begin
      @(negedge clk);
      cyc++;
      if (ucnt > 0) ucnt--;
      if (transmit) ucnt = $urandom_range(1, 6);
      is_transmitting = (ucnt > 0);
      received = 1'b0;
      send = 1'b0;
      rx_byte = 8'($urandom);
      tmp = {$urandom(), $urandom()};
      m_in = tmp[39:0];
      cmd = 2'($urandom);
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) rst_n = 1'b1;
        chk_reset_vals("reset_hold");
      end else begin
        chk(done == (phase != P_IDLE &&
                     cyc == exp_done),
            "done", done, cyc == exp_done);
        chk(busy == (phase != P_IDLE &&
                     cyc > acc && cyc < exp_done),
            "busy", busy, !busy);
        flags = {ack_ok, nack, timeout};
        if (phase == P_IDLE)
          chk(flags == exp_flags, "flags_idle",
              flags, exp_flags);
        else
          chk($countones(flags) <= 1,
              "flags_onehot", flags, 0);
        if (transmit) begin
          chk(exp_q.size() != 0, "extra_byte",
              tx_byte, 0);
          if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            chk(tx_byte == b, "tx_byte", tx_byte, b);
          end
          rec_q.push_back(tx_byte);
          if (first_tx) begin
            chk(cyc == acc + 2, "first_tx_lat",
                cyc - acc, 2);
            first_tx = 0;
          end
          last_tx = cyc;
          bytes_sent++;
        end
        case (phase)
          P_IDLE: begin
            if (go) begin
              go = 0;
              send = 1'b1;
              cmd = p_cmd;
              m_in = p_m;
              acc = cyc;
              build(p_cmd, p_m);
              rec_q.delete();
              first_tx = 1;
              bytes_sent = 0;
              early_done = 0;
              if (p_cmd == 2'd3) begin
                phase = P_ACK;
                wa = BIG;
                exp_done = cyc + 2;
                exp_res = 3'b010;
                first_tx = 0;
              end else begin
                phase = P_TX;
                exp_done = BIG;
              end
            end
          end
          P_TX: begin
            if (p_mid && cyc > acc &&
                $urandom_range(0, 2) == 0)
              send = 1'b1;
            if (p_early && !early_done &&
                bytes_sent > 0 &&
                cyc >= last_tx + 2 &&
                is_transmitting) begin
              received = 1'b1;
              rx_byte = 8'h06;
              early_done = 1;
            end
            if (exp_q.size() == 0 && bytes_sent > 0 &&
                cyc >= last_tx + 2 &&
                !is_transmitting) begin
              phase = P_ACK;
              wa = cyc + 1;
              valid = (p_rb == 8'h06) ||
                      (p_rb == 8'h15);
              if (valid && p_rw <= T - 1) begin
                exp_done = wa + p_rw + 2;
                exp_res = (p_rb == 8'h06) ? 3'b100
                                          : 3'b010;
              end else begin
                exp_done = wa + T + 1;
                exp_res = 3'b001;
              end
            end else if (p_rst > 0 &&
                         bytes_sent == p_rst &&
                         cyc == last_tx + 1) begin
              rst_n = 1'b0;
              #1;
              chk_reset_vals("reset_async");
              phase = P_IDLE;
              exp_flags = '0;
              exp_q.delete();
              exp_done = BIG;
              rst_cnt = 2;
              complete = 1;
            end
          end
          default: begin
            if (cyc == exp_done) begin
              chk(flags == exp_res, "result",
                  flags, exp_res);
              phase = P_IDLE;
              exp_flags = exp_res;
              done_at = cyc;
              complete = 1;
            end else if (cyc >= wa) begin
              w = cyc - wa;
              if (p_rb != 8'h00 && w == p_rw) begin
                received = 1'b1;
                rx_byte = p_rb;
              end else if (w == p_jw) begin
                received = 1'b1;
                rx_byte = 8'h41;
              end
            end
          end
        endcase
      end
    end
  end

  task automatic run(
    input logic [1:0] c, input logic [39:0] m,
    input logic [7:0] rb, input int rw,
    input int jw, input bit early,
    input bit mid, input int rst_after
  );
    @(posedge clk);
    p_cmd = c;
    p_m = m;
    p_rb = rb;
    p_rw = rw;
    p_jw = jw;
    p_early = early;
    p_mid = mid;
    p_rst = rst_after;
    complete = 0;
    go = 1;
    for (int i = 0; i < 1000 && !complete; i++)
      @(posedge clk);
    if (!complete) begin
      chk(complete, "txn_timeout", 0, 1);
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $fatal(1, "transaction stalled");
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  logic [7:0] lit1 [7] = '{8'h46, 8'h01, 8'h23,
                           8'h45, 8'h67, 8'h89,
                           8'hCF};
  logic [63:0] rnd;

  initial begin
    repeat (6) @(posedge clk);

    run(2'd0, 40'h01_2345_6789, 8'h06, 3, 1,
        1, 1, 0);
    chk(rec_q.size() == 7, "t1_len", rec_q.size(), 7);
    for (int i = 0; i < 7 && i < rec_q.size(); i++)
      chk(rec_q[i] == lit1[i], "t1_byte",
          rec_q[i], lit1[i]);
    chk({ack_ok, nack, timeout} == 3'b100, "t1_ack",
        {ack_ok, nack, timeout}, 3'b100);

    run(2'd1, 40'h0, 8'h15, 2, 0, 0, 0, 0);
    chk(rec_q.size() == 2 && rec_q[0] == 8'h45 &&
        rec_q[1] == 8'h45, "t2_bytes",
        {rec_q[0], rec_q[1]}, 16'h4545);
    chk(nack === 1'b1, "t2_nack", nack, 1);

    run(2'd2, 40'h0, 8'h06, 0, 7, 0, 1, 0);
    chk(rec_q.size() == 2 && rec_q[0] == 8'h44 &&
        rec_q[1] == 8'h44, "t3_bytes",
        {rec_q[0], rec_q[1]}, 16'h4444);
    chk({ack_ok, nack} == 2'b10, "t3_flags",
        {ack_ok, nack}, 2'b10);

    run(2'd0, 40'hA5_5A3C_C3F0, 8'h00, 0, 5,
        0, 0, 0);
    chk(done_at - wa == 51, "t4_to_lat",
        done_at - wa, 51);
    chk(timeout === 1'b1, "t4_timeout", timeout, 1);

    run(2'd1, 40'h0, 8'h06, T - 1, 2, 0, 0, 0);
    chk({ack_ok, timeout} == 2'b10, "t5_race",
        {ack_ok, timeout}, 2'b10);

    run(2'd3, 40'h0, 8'h00, 0, 0, 0, 0, 0);
    chk(done_at - acc == 2, "t6_lat",
        done_at - acc, 2);
    chk(rec_q.size() == 0, "t6_nobytes",
        rec_q.size(), 0);
    chk(nack === 1'b1, "t6_nack", nack, 1);

    run(2'd0, 40'hDE_ADBE_EF01, 8'h06, 4, 1,
        0, 0, 3);
    chk(rec_q.size() == 3, "t7_partial",
        rec_q.size(), 3);
    run(2'd0, 40'h11_2233_4455, 8'h06, 1, 9,
        0, 0, 0);
    chk(rec_q.size() == 7 && rec_q[0] == 8'h46,
        "t7_restart", rec_q[0], 8'h46);

    for (int n = 0; n < 24; n++) begin
      logic [7:0] rb;
      rnd = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0: rb = 8'h06;
        1: rb = 8'h15;
        2: rb = 8'h41;
        default: rb = 8'h00;
      endcase
      run(2'($urandom), rnd[39:0], rb,
          $urandom_range(0, T + 3),
          $urandom_range(0, 20),
          1'($urandom), 1'($urandom), 0);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
